// File: rtl/tile_pkg.sv
// Shared types for the tile transmit path: flit width, flit type codes,
// header field layout and the packetizer FSM state encoding.
package tile_pkg;

  localparam int FLIT_W = 37;
  localparam int SEQ_W  = 11;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_HEAD      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    logic [7:0]       dest;
    logic [7:0]       src;
    logic [7:0]       len;
    logic [SEQ_W-1:0] seq;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_DROP
  } tx_state_e;

endpackage

// File: rtl/tile_tx_flit_reg.sv
// Single-entry output register in front of the dual-clock tile FIFO.
// It can be reloaded in the same cycle it drains, so back-to-back flits
// flow without a bubble while the FIFO is not full.
module tile_tx_flit_reg
  import tile_pkg::*;
(
  input  logic              wr_clk,
  input  logic              srst,
  input  logic              load,
  input  logic [FLIT_W-1:0] load_data,
  output logic              reg_free,
  output logic [FLIT_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_wr_rst_busy
);

  logic              reg_valid_q, reg_valid_d;
  logic [FLIT_W-1:0] reg_data_q,  reg_data_d;

  // With the FIFO able to take data, the register is either empty or
  // draining this cycle, so the producer may load a new flit.
  assign reg_free   = ~fifo_full & ~fifo_wr_rst_busy;
  assign fifo_wr_en = reg_valid_q & ~fifo_full & ~fifo_wr_rst_busy & ~srst;
  assign fifo_din   = reg_data_q;

  // Next register contents: drain on a FIFO write, refill on load; data holds otherwise.
  always_comb begin
    reg_valid_d = reg_valid_q;
    reg_data_d  = reg_data_q;
    if (fifo_wr_en) begin
      reg_valid_d = 1'b0;
    end
    if (load) begin
      reg_valid_d = 1'b1;
      reg_data_d  = load_data;
    end
  end

  // Register update with synchronous reset clearing both flag and data.
  always_ff @(posedge wr_clk) begin
    if (srst) begin
      reg_valid_q <= 1'b0;
      reg_data_q  <= '0;
    end else begin
      reg_valid_q <= reg_valid_d;
      reg_data_q  <= reg_data_d;
    end
  end

endmodule

// File: rtl/tile_tx_packetizer.sv
// Tile transmit packetizer: turns a message descriptor plus payload words
// into head/body/tail flits for the tile FIFO. Oversize messages are
// consumed and discarded with a sticky error flag.
// Optional feature: define TILE_TX_SEQ_EN to carry an 11-bit header
// sequence number; otherwise the header sequence field is zero.
module tile_tx_packetizer
  import tile_pkg::*;
#(
  parameter logic [7:0] SRC_ID  = 8'h00,
  parameter int         MAX_LEN = 64
) (
  input  logic              wr_clk,
  input  logic              srst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [7:0]        msg_dest,
  input  logic [7:0]        msg_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [31:0]       data,
  output logic [FLIT_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_wr_rst_busy,
  output logic              err_len,
  output logic [15:0]       msg_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  tx_state_e         state_q, state_d;
  logic [7:0]        dest_q, dest_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_len_q, err_len_d;
  logic [15:0]       msg_cnt_q, msg_cnt_d;
  logic              reg_free;
  logic              load;
  logic [FLIT_W-1:0] load_data;
  logic              hdr_load;
  logic              msg_accept;
  logic              data_accept;
  logic [SEQ_W-1:0]  seq;
  hdr_t              hdr;
  flit_type_e        ftype;

  assign msg_ready   = (state_q == ST_IDLE) & reg_free & ~srst;
  assign data_ready  = ((state_q == ST_BODY) | (state_q == ST_DROP)) & reg_free & ~srst;
  assign msg_accept  = msg_valid & msg_ready;
  assign data_accept = data_valid & data_ready;
  assign hdr_load    = (state_q == ST_HEAD) & reg_free;
  assign err_len     = err_len_q;
  assign msg_cnt     = msg_cnt_q;

`ifdef TILE_TX_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;

  // Sequence number advances on every header loaded, wrapping naturally.
  always_comb begin
    seq_d = seq_q;
    if (hdr_load) begin
      seq_d = seq_q + 11'd1;
    end
  end

  // Sequence counter register.
  always_ff @(posedge wr_clk) begin
    if (srst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq = seq_q;
`else
  assign seq = '0;
`endif

  // Next-state, flit assembly and counter logic for the packetizer FSM.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_len_d = err_len_q;
    msg_cnt_d = msg_cnt_q;
    load      = 1'b0;
    load_data = '0;
    ftype     = FLIT_BODY;
    hdr.dest  = dest_q;
    hdr.src   = SRC_ID;
    hdr.len   = len_q;
    hdr.seq   = seq;

    case (state_q)
      ST_IDLE: begin
        if (msg_accept) begin
          dest_d = msg_dest;
          len_d  = msg_len;
          cnt_d  = msg_len;
          if (msg_len > MAX_LEN_B) begin
            state_d   = ST_DROP;
            err_len_d = 1'b1;
          end else begin
            state_d = ST_HEAD;
          end
        end
      end
      ST_HEAD: begin
        if (hdr_load) begin
          ftype     = (len_q == 8'd0) ? FLIT_HEAD_TAIL : FLIT_HEAD;
          load      = 1'b1;
          load_data = {ftype, hdr};
          state_d   = (len_q == 8'd0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (data_accept) begin
          ftype     = (cnt_q == 8'd1) ? FLIT_TAIL : FLIT_BODY;
          load      = 1'b1;
          load_data = {ftype, 3'b000, data};
          cnt_d     = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (data_accept) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_wr_en && fifo_din[FLIT_W-1]) begin
      msg_cnt_d = msg_cnt_q + 16'd1;
    end
  end

  // FSM state, latched descriptor and status registers.
  always_ff @(posedge wr_clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_len_q <= 1'b0;
      msg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  tile_tx_flit_reg u_flit_reg (
    .wr_clk           (wr_clk),
    .srst             (srst),
    .load             (load),
    .load_data        (load_data),
    .reg_free         (reg_free),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_wr_rst_busy (fifo_wr_rst_busy)
  );

endmodule

// File: tb/tb_tile_tx_packetizer.sv
// Directed bench for tile_tx_packetizer: a vector table of whole messages
// plus hand-written sequences for FIFO stall, mid-message reset and
// sequence-number wrap. Every FIFO write is checked against a queue of
// expected flits built from the message descriptions.
module tb_tile_tx_packetizer;
  import tile_pkg::*;

  logic              wr_clk = 1'b0;
  logic              srst;
  logic              msg_valid;
  logic              msg_ready;
  logic [7:0]        msg_dest;
  logic [7:0]        msg_len;
  logic              data_valid;
  logic              data_ready;
  logic [31:0]       data;
  logic [FLIT_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              fifo_wr_rst_busy;
  logic              err_len;
  logic [15:0]       msg_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int wr_count = 0;
  int hdr_count = 0;
  int exp_msgs = 0;
  logic [FLIT_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0]  dest;
    logic [7:0]  len;
    logic [31:0] base;
    int          exp_writes;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  always #5 wr_clk = ~wr_clk;

  tile_tx_packetizer #(
    .SRC_ID  (8'h02),
    .MAX_LEN (64)
  ) dut (
    .wr_clk           (wr_clk),
    .srst             (srst),
    .msg_valid        (msg_valid),
    .msg_ready        (msg_ready),
    .msg_dest         (msg_dest),
    .msg_len          (msg_len),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .data             (data),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_wr_rst_busy (fifo_wr_rst_busy),
    .err_len          (err_len),
    .msg_cnt          (msg_cnt)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Every FIFO write must match the next expected flit, in order.
  always @(negedge wr_clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_write: got %0h, expected no write", fifo_din);
      end else begin
        check_output("flit", 64'(fifo_din), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FLIT_W-1:0] hdr_flit(input logic [7:0] dest, input logic [7:0] len);
    logic [10:0] s;
    logic [1:0]  t;
`ifdef TILE_TX_SEQ_EN
    s = hdr_count[10:0];
`else
    s = 11'd0;
`endif
    t = (len == 8'd0) ? 2'b11 : 2'b01;
    return {t, dest, 8'h02, len, s};
  endfunction

  task automatic push_msg(input logic [7:0] dest, input logic [7:0] len, input logic [31:0] base);
    exp_q.push_back(hdr_flit(dest, len));
    hdr_count++;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b00, 3'b000, base + 32'(i)});
    end
    exp_msgs++;
  endtask

  task automatic step();
    @(posedge wr_clk);
    #2;
  endtask

  task automatic send_msg(input logic [7:0] dest, input logic [7:0] len);
    bit ok = 1'b0;
    msg_valid = 1'b1;
    msg_dest  = dest;
    msg_len   = len;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      ok = msg_ready;
      step();
    end
    msg_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("[TB] FAIL msg_handshake: got no msg_ready, expected accept");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 1'b0;
    data_valid = 1'b1;
    data       = w;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      ok = data_ready;
      step();
    end
    data_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("[TB] FAIL data_handshake: got no data_ready, expected accept");
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] dest, input logic [7:0] len, input logic [31:0] base);
    send_msg(dest, len);
    for (int i = 0; i < int'(len); i++) send_word(base + 32'(i));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge wr_clk);
      done = (exp_q.size() == 0) && (msg_ready === 1'b1);
    end
    if (!done) begin
      n_total++;
      $display("[TB] FAIL drain: got %0d flits pending, expected 0", exp_q.size());
    end
    step();
  endtask

  initial begin
    logic [FLIT_W-1:0] hdr;
    int w0;

    vecs[0] = '{8'h05, 8'd3,   32'h0000_00A0, 4,  1'b0};
    vecs[1] = '{8'h09, 8'd0,   32'h0000_0000, 1,  1'b0};
    vecs[2] = '{8'h11, 8'd1,   32'h0000_1000, 2,  1'b0};
    vecs[3] = '{8'h22, 8'd64,  32'h0000_2000, 65, 1'b0};
    vecs[4] = '{8'h33, 8'd65,  32'h0000_3000, 0,  1'b1};
    vecs[5] = '{8'h44, 8'd100, 32'h0000_4000, 0,  1'b1};
    vecs[6] = '{8'h55, 8'd2,   32'h0000_5000, 3,  1'b1};

    srst = 1'b1; msg_valid = 1'b0; msg_dest = '0; msg_len = '0;
    data_valid = 1'b0; data = '0; fifo_full = 1'b0; fifo_wr_rst_busy = 1'b0;

    // Reset state
    step(); step();
    #1;
    check_output("rst_msg_ready", 64'(msg_ready), 64'd0);
    check_output("rst_data_ready", 64'(data_ready), 64'd0);
    check_output("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    step();
    srst = 1'b0;
    #1;
    check_output("rst_din", 64'(fifo_din), 64'd0);
    check_output("rst_err_len", 64'(err_len), 64'd0);
    check_output("rst_msg_cnt", 64'(msg_cnt), 64'd0);
    check_output("idle_msg_ready", 64'(msg_ready), 64'd1);
    fifo_wr_rst_busy = 1'b1;
    #1;
    check_output("busy_msg_ready", 64'(msg_ready), 64'd0);
    fifo_wr_rst_busy = 1'b0;
    step();

    // Table of whole messages
    for (int v = 0; v < 7; v++) begin
      w0 = wr_count;
      if (vecs[v].exp_writes > 0) push_msg(vecs[v].dest, vecs[v].len, vecs[v].base);
      apply_stimulus(vecs[v].dest, vecs[v].len, vecs[v].base);
      wait_idle();
      check_output($sformatf("v%0d_writes", v), 64'(wr_count - w0), 64'(vecs[v].exp_writes));
      check_output($sformatf("v%0d_err_len", v), 64'(err_len), 64'(vecs[v].exp_err));
      check_output($sformatf("v%0d_msg_cnt", v), 64'(msg_cnt), 64'(exp_msgs));
    end

    // FIFO full for five cycles right after the header is registered
    w0  = wr_count;
    hdr = hdr_flit(8'h5A, 8'd3);
    push_msg(8'h5A, 8'd3, 32'h0000_00C0);
    send_msg(8'h5A, 8'd3);
    step();
    fifo_full  = 1'b1;
    data_valid = 1'b1;
    data       = 32'h0000_00C0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_output("stall_wr_en", 64'(fifo_wr_en), 64'd0);
      check_output("stall_data_ready", 64'(data_ready), 64'd0);
      check_output("stall_din", 64'(fifo_din), 64'(hdr));
      step();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'h0000_00C0 + 32'(i));
    wait_idle();
    check_output("stall_writes", 64'(wr_count - w0), 64'd4);
    check_output("stall_msg_cnt", 64'(msg_cnt), 64'(exp_msgs));

    // Reset after the second of four payload words
    w0 = wr_count;
    exp_q.push_back(hdr_flit(8'h77, 8'd4));
    hdr_count++;
    exp_q.push_back({2'b00, 3'b000, 32'h0000_7000});
    exp_q.push_back({2'b00, 3'b000, 32'h0000_7001});
    send_msg(8'h77, 8'd4);
    send_word(32'h0000_7000);
    send_word(32'h0000_7001);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    srst       = 1'b1;
    data_valid = 1'b1;
    data       = 32'h0000_7002;
    #1;
    check_output("srst_data_ready", 64'(data_ready), 64'd0);
    check_output("srst_msg_ready", 64'(msg_ready), 64'd0);
    check_output("srst_wr_en", 64'(fifo_wr_en), 64'd0);
    step();
    srst = 1'b0;
    hdr_count = 0;
    exp_msgs  = 0;
    #1;
    check_output("post_srst_din", 64'(fifo_din), 64'd0);
    check_output("post_srst_err_len", 64'(err_len), 64'd0);
    check_output("post_srst_msg_cnt", 64'(msg_cnt), 64'd0);
    check_output("post_srst_data_ready", 64'(data_ready), 64'd0);
    for (int c = 0; c < 4; c++) step();
    data_valid = 1'b0;
    check_output("srst_writes", 64'(wr_count - w0), 64'd3);

    // Sequence field across a full wrap of 2049 zero-length messages
    for (int m = 0; m < 2049; m++) begin
      push_msg(8'h60, 8'd0, 32'd0);
      send_msg(8'h60, 8'd0);
    end
    wait_idle();
    check_output("seq_msg_cnt", 64'(msg_cnt), 64'd2049);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
